// File: rtl/iter_div.sv
// Multi-cycle 32-bit restoring divider for the execute stage.
// Signed/unsigned per operation, AXI-stream style operand and result channels.
module iter_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tuser,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    output logic        m_axis_dout_tvalid,
    input  logic        m_axis_dout_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic        dvd_captured;
    logic        dvs_captured;
    logic [31:0] dvd_held;
    logic [31:0] dvs_held;
    logic        signed_held;

    logic        idle;
    logic        dvd_fire;
    logic        dvs_fire;
    logic        start;
    logic [31:0] dvd_op;
    logic [31:0] dvs_op;
    logic        signed_op;
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs_mag;
    logic [31:0] dvd_orig;
    logic [4:0]  count;
    logic        sign_q;
    logic        sign_r;
    logic        div_zero;
    logic [63:0] result;

    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        last;

    // Operand ports
    always_comb begin
        idle = (state == IDLE);
        s_axis_dividend_tready = idle && !dvd_captured && !flush && !reset;
        s_axis_divisor_tready  = idle && !dvs_captured && !flush && !reset;
        dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
        dvs_fire = s_axis_divisor_tvalid && s_axis_divisor_tready;
        start = idle && !flush && !reset
              && (dvd_captured || dvd_fire)
              && (dvs_captured || dvs_fire);
    end

    // Operands may arrive this cycle or have been held from an earlier one
    always_comb begin
        dvd_op    = dvd_captured ? dvd_held : s_axis_dividend_tdata;
        dvs_op    = dvs_captured ? dvs_held : s_axis_divisor_tdata;
        signed_op = dvd_captured ? signed_held : s_axis_dividend_tuser;
        dvd_neg   = signed_op && dvd_op[31];
        dvs_neg   = signed_op && dvs_op[31];
        dvd_abs   = dvd_neg ? (32'd0 - dvd_op) : dvd_op;
        dvs_abs   = dvs_neg ? (32'd0 - dvs_op) : dvs_op;
    end

    // One restoring step; quo shifts dividend bits out as quotient bits shift in
    always_comb begin
        rem_shift = {rem, quo[31]};
        diff      = rem_shift - {1'b0, dvs_mag};
        rem_step  = diff[32] ? rem_shift[31:0] : diff[31:0];
        quo_step  = {quo[30:0], ~diff[32]};
        last      = (count == 5'd31);
    end

    always_comb begin
        quo_fix = sign_q ? (32'd0 - quo_step) : quo_step;
        rem_fix = sign_r ? (32'd0 - rem_step) : rem_step;
        if (div_zero) begin
            quo_fix = 32'hFFFF_FFFF;
            rem_fix = dvd_orig;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = CALC;
            CALC: if (last) state_next = DONE;
            DONE: if (m_axis_dout_tready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dvd_captured <= 1'b0;
            dvs_captured <= 1'b0;
            dvd_held     <= '0;
            dvs_held     <= '0;
            signed_held  <= 1'b0;
            rem          <= '0;
            quo          <= '0;
            dvs_mag      <= '0;
            dvd_orig     <= '0;
            count        <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            div_zero     <= 1'b0;
            result       <= '0;
        end else begin
            state <= state_next;

            if (flush || start) begin
                dvd_captured <= 1'b0;
                dvs_captured <= 1'b0;
            end else begin
                if (dvd_fire) begin
                    dvd_captured <= 1'b1;
                    dvd_held     <= s_axis_dividend_tdata;
                    signed_held  <= s_axis_dividend_tuser;
                end
                if (dvs_fire) begin
                    dvs_captured <= 1'b1;
                    dvs_held     <= s_axis_divisor_tdata;
                end
            end

            if (start) begin
                rem      <= '0;
                quo      <= dvd_abs;
                dvs_mag  <= dvs_abs;
                dvd_orig <= dvd_op;
                count    <= '0;
                sign_q   <= dvd_neg ^ dvs_neg;
                sign_r   <= dvd_neg;
                div_zero <= (dvs_op == 32'd0);
            end else if (state == CALC) begin
                rem   <= rem_step;
                quo   <= quo_step;
                count <= count + 5'd1;
                if (last && !flush) result <= {quo_fix, rem_fix};
            end
        end
    end

    assign m_axis_dout_tvalid = (state == DONE);
    assign m_axis_dout_tdata  = result;
    assign busy               = (state != IDLE);

endmodule

// File: tb/tb_iter_div.sv
// Directed self-checking bench for iter_div.
// Covers latency, signed/unsigned results, div-by-zero, split handshakes, flush, reset.
module tb_iter_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        dvd_valid;
    logic        dvd_ready;
    logic [31:0] dvd_data;
    logic        dvd_user;
    logic        dvs_valid;
    logic        dvs_ready;
    logic [31:0] dvs_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [63:0] dout_data;
    logic        busy;

    int tests = 0;
    int failed = 0;
    int cyc;

    iter_div dut (
        .clk                    (clk),
        .reset                  (reset),
        .flush                  (flush),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tuser  (dvd_user),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready),
        .s_axis_divisor_tdata   (dvs_data),
        .m_axis_dout_tvalid     (dout_valid),
        .m_axis_dout_tready     (dout_ready),
        .m_axis_dout_tdata      (dout_data),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance until dout_tvalid rises; cyc tracks the current cycle index
    task automatic wait_valid(input int start_cyc, output int at);
        at = start_cyc;
        while (!dout_valid && at < start_cyc + 60) begin
            tick();
            at++;
        end
        if (!dout_valid) at = -1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp, input int hold);
        int at;
        dvd_valid = 1'b1;
        dvd_data  = a;
        dvd_user  = sgn;
        dvs_valid = 1'b1;
        dvs_data  = b;
        tick();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        wait_valid(1, at);
        check({tag, " latency"}, 64'(at), 64'd33);
        check({tag, " data"}, dout_data, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold valid"}, {63'd0, dout_valid}, 64'd1);
            check({tag, " hold data"}, dout_data, exp);
        end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check({tag, " drained"}, {62'd0, dout_valid, busy}, 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        dvd_valid  = 1'b0;
        dvd_data   = '0;
        dvd_user   = 1'b0;
        dvs_valid  = 1'b0;
        dvs_data   = '0;
        dout_ready = 1'b0;

        tick();
        tick();
        check("reset treadys", {62'd0, dvd_ready, dvs_ready}, 64'd0);
        reset = 1'b0;
        tick();
        check("idle treadys", {62'd0, dvd_ready, dvs_ready}, 64'd3);
        check("reset valid/busy", {62'd0, dout_valid, busy}, 64'd0);
        check("reset tdata", dout_data, 64'd0);

        run_op("u100/7", 32'd100, 32'd7, 1'b0, {32'h0000000E, 32'h00000002}, 5);
        run_op("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFD, 32'hFFFFFFFF}, 0);
        run_op("s7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'hFFFFFFFD, 32'h00000001}, 0);
        run_op("s ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'h0}, 0);
        run_op("u div0", 32'h12345678, 32'd0, 1'b0, {32'hFFFFFFFF, 32'h12345678}, 0);
        run_op("s div0", 32'hFFFFFFFB, 32'd0, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFB}, 0);
        run_op("u big", 32'hFFFFFFFF, 32'd3, 1'b0, {32'h55555555, 32'h0}, 0);

        // Split handshake: dividend at cycle 0, divisor at cycle 4
        dvd_valid = 1'b1;
        dvd_data  = 32'd50;
        dvd_user  = 1'b0;
        tick();
        dvd_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                dvs_valid = 1'b1;
                dvs_data  = 32'd5;
            end
            check("split dvd tready low", {63'd0, dvd_ready}, 64'd0);
            check("split dvs tready high", {63'd0, dvs_ready}, 64'd1);
            if (c < 4) tick();
        end
        tick();
        dvs_valid = 1'b0;
        wait_valid(5, cyc);
        check("split latency", 64'(cyc), 64'd37);
        check("split data", dout_data, {32'd10, 32'd0});
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;

        // Flush in IDLE blocks a handshake
        flush     = 1'b1;
        dvd_valid = 1'b1;
        dvd_data  = 32'd77;
        #1;
        check("flush tready", {62'd0, dvd_ready, dvs_ready}, 64'd0);
        tick();
        flush     = 1'b0;
        dvd_valid = 1'b0;
        #1;
        check("flush no capture", {62'd0, dvd_ready, busy}, 64'd2);

        // Flush in the tenth CALC cycle
        dvd_valid = 1'b1;
        dvd_data  = 32'd1000;
        dvs_valid = 1'b1;
        dvs_data  = 32'd3;
        tick();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("pre-flush busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("post-flush idle", {60'd0, busy, dout_valid, dvd_ready, dvs_ready}, 64'd3);
        for (int c = 0; c < 40; c++) begin
            tick();
            if (dout_valid) break;
        end
        check("post-flush no valid", {63'd0, dout_valid}, 64'd0);
        run_op("9/3", 32'd9, 32'd3, 1'b0, {32'd3, 32'd0}, 0);

        // Back-to-back with dout_tready tied high
        dout_ready = 1'b1;
        dvd_valid  = 1'b1;
        dvd_data   = 32'd1000;
        dvd_user   = 1'b0;
        dvs_valid  = 1'b1;
        dvs_data   = 32'd10;
        tick();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        wait_valid(1, cyc);
        check("b2b first latency", 64'(cyc), 64'd33);
        check("b2b first data", dout_data, {32'd100, 32'd0});
        dvd_valid = 1'b1;
        dvd_data  = 32'hFFFFFFFF;
        dvs_valid = 1'b1;
        dvs_data  = 32'd1;
        check("b2b tready in DONE", {62'd0, dvd_ready, dvs_ready}, 64'd0);
        tick();
        check("b2b tready next", {61'd0, dout_valid, dvd_ready, dvs_ready}, 64'd3);
        tick();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        wait_valid(1, cyc);
        check("b2b second latency", 64'(cyc), 64'd33);
        check("b2b second data", dout_data, {32'hFFFFFFFF, 32'd0});
        tick();
        dout_ready = 1'b0;
        check("b2b drained", {63'd0, dout_valid}, 64'd0);

        // Reset mid-CALC clears the output register
        dvd_valid = 1'b1;
        dvd_data  = 32'd20;
        dvs_valid = 1'b1;
        dvs_data  = 32'd4;
        tick();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid reset tdata", dout_data, 64'd0);
        check("mid reset state", {61'd0, busy, dout_valid, dvd_ready}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/iter_div.md
# iter_div

Multi-cycle 32-bit integer divider that serves as the responder on the execute stage's divide-request interface. Accepts dividend and divisor on two independent valid/ready channels, runs a 32-iteration restoring division, and returns quotient and remainder on a valid/ready result channel. One instance handles both DIV/MOD (signed) and DIVU/MODU (unsigned), selected per operation. Replaces the vendor divider IP in the execute stage.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous abort of any in-flight or pending operation
- s_axis_dividend_tvalid  in  1  dividend offered
- s_axis_dividend_tready  out  1  dividend can be captured this cycle
- s_axis_dividend_tdata  in  32  dividend
- s_axis_dividend_tuser  in  1  1 = signed operation, 0 = unsigned; captured with dividend
- s_axis_divisor_tvalid  in  1  divisor offered
- s_axis_divisor_tready  out  1  divisor can be captured this cycle
- s_axis_divisor_tdata  in  32  divisor
- m_axis_dout_tvalid  out  1  result available, held until accepted
- m_axis_dout_tready  in  1  consumer accepts result
- m_axis_dout_tdata  out  64  [63:32] quotient, [31:0] remainder
- busy  out  1  high in CALC and DONE

## Operation
- States: IDLE, CALC, DONE. Reset and flush both force IDLE, clear both capture flags, deassert dout_tvalid.
- IDLE: dividend_tready = !dvd_captured && !flush; divisor_tready = !dvs_captured && !flush. Each channel handshakes independently (tvalid && tready); data and tuser latched on its own handshake; flag set.
- Start: when both operands are held (captured earlier or handshaking this cycle), at that edge compute absolute values (signed mode, negative operand: two's complement; 0x80000000 stays 0x80000000 as unsigned magnitude), record sign_q = sign(dvd) ^ sign(dvs) and sign_r = sign(dvd), clear flags, counter = 0, go CALC.
- CALC: one quotient bit per cycle, MSB first. 33-bit partial remainder: shift in next dividend bit, trial-subtract divisor magnitude; non-negative -> keep difference, quotient bit 1; else restore, bit 0. Counter 0..31; on the edge ending count 31, apply sign fix and load output register, go DONE.
- Sign fix (signed mode): quotient negated if sign_q; remainder negated if sign_r. Quotient truncates toward zero; remainder takes dividend's sign.
- Divisor zero (either mode): quotient = 0xFFFFFFFF, remainder = original dividend. Decided at start; CALC still runs full 32 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (falls out of magnitude arithmetic).
- DONE: dout_tvalid = 1, tdata stable. On dout_tready go IDLE. Both input treadys low in CALC and DONE.

## Timing
- Reset values: both treadys 0 during reset cycle, 1 in first IDLE cycle after; dout_tvalid 0; dout_tdata 0; busy 0.
- Latency: start edge at end of cycle T; CALC occupies T+1..T+32; dout_tvalid high from T+33.
- Result handshake cycle D: IDLE at D+1, earliest new operand capture at D+1; minimum issue interval 34 cycles with immediate acceptance.
- Split handshakes: dividend at T0, divisor at T1 > T0 -> start edge at T1; dividend tready low from T0+1 until next IDLE.
- flush high in any cycle: no handshake accepted that cycle, IDLE next cycle; result in DONE discarded even if dout_tready also high. flush wins over start.
- Reset mid-CALC: identical to flush plus output register cleared.
- dout_tvalid never drops without dout_tready, flush or reset.

## Test plan
- Unsigned: 100 / 7 both valid same cycle -> dout_tvalid exactly 33 cycles later, tdata = {0x0000000E, 0x00000002}; dout_tready held low 5 cycles -> value and valid stable.
- Signed: -7 / 2 -> {0xFFFFFFFD, 0xFFFFFFFF}; 7 / -2 -> {0xFFFFFFFD, 0x00000001}; 0x80000000 / -1 -> {0x80000000, 0x00000000}.
- Divide by zero: unsigned 0x12345678 / 0 and signed -5 / 0 -> quotients 0xFFFFFFFF, remainders 0x12345678 and 0xFFFFFFFB.
- Split handshake: dividend valid at cycle 0, divisor valid at cycle 4 -> dividend_tready low cycles 1-4, result valid at cycle 37.
- Flush at CALC cycle 10 -> IDLE next cycle, no dout_tvalid; new 9 / 3 after flush -> {3, 0} with full 33-cycle latency.
- Back-to-back: 1000 / 10 then 0xFFFFFFFF / 1 unsigned, dout_tready tied high -> second accepted the cycle after first result handshake, results {100, 0} and {0xFFFFFFFF, 0}.
